rvc_asap_5pl_vga_fill_arb: RTL and testbench

Shares the core-side port of the VGA frame-buffer memory between core loads/stores and a hardware fill/copy engine.
- Fill: clears or paints a region with a 32-bit pattern.
- Copy: moves a word range, used for scroll-up.
- Core accesses always win the port; the engine advances only in cycles the core leaves free.
- Sits between the 5-stage pipeline's VGA memory control signals and the frame-buffer port A, in the CLK_50 domain.

---
 rtl/rvc_asap_5pl_vga_fill_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_rvc_asap_5pl_vga_fill_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_asap_5pl_vga_fill_arb.sv
// ---------------------------------------------------------------------------
// rvc_asap_5pl_vga_fill_arb
//
// Shares the core-side port (port A) of the VGA frame-buffer memory between
// the 5-stage pipeline's loads/stores and a fill/copy engine. The core always
// wins the port; the engine only advances in cycles the core leaves free.
//
//   Fill : writes a 32-bit pattern to CmdLen words starting at CmdDst.
//   Copy : copies CmdLen words from CmdSrc to CmdDst in ascending order
//          (correct for Dst <= Src, i.e. scroll-up; Dst > Src smears).
//
// Ports
//   CLK_50, Reset_N           clock, asynchronous active-low reset
//   CoreWrEn/RdEn/Addr/...    core access request; forwarded unchanged
//   CmdValid/CmdReady         command handshake (CmdReady = engine idle)
//   CmdOp/Src/Dst/Len/Data    command fields (Op 0 = fill, 1 = copy)
//   Busy, Done                engine operating / one-cycle completion pulse
//   Mem*                      frame-buffer port A; MemRdData is registered
//                             and valid one cycle after MemRdEn
//
// ADDR_W must be wide enough to address WORDS (2**ADDR_W >= WORDS).
// ---------------------------------------------------------------------------
module rvc_asap_5pl_vga_fill_arb #(
    parameter int unsigned WORDS  = 9600,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              CLK_50,
    input  logic              Reset_N,
    // Core side
    input  logic              CoreWrEn,
    input  logic              CoreRdEn,
    input  logic [ADDR_W-1:0] CoreAddr,
    input  logic [31:0]       CoreWrData,
    input  logic [3:0]        CoreByteEn,
    // Engine command
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic              CmdOp,
    input  logic [ADDR_W-1:0] CmdSrc,
    input  logic [ADDR_W-1:0] CmdDst,
    input  logic [ADDR_W:0]   CmdLen,
    input  logic [31:0]       CmdData,
    output logic              Busy,
    output logic              Done,
    // Frame-buffer port A
    output logic              MemWrEn,
    output logic              MemRdEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWrData,
    output logic [3:0]        MemByteEn,
    input  logic [31:0]       MemRdData
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCpRd,
        StCpWait,
        StCpWr,
        StDone
    } state_e;

    // Next word address, wrapping WORDS-1 back to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(WORDS - 1)) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    // Command addresses beyond the frame buffer are folded back into range.
    function automatic logic [ADDR_W-1:0] mod_words(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) % WORDS;
        return ADDR_W'(t);
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         buf_q, buf_d;

    logic                core_act;
    logic                eng_gnt;
    logic                eng_wr;
    logic                eng_rd;
    logic [ADDR_W-1:0]   eng_addr;
    logic [31:0]         eng_data;

    assign core_act = CoreWrEn || CoreRdEn;
    assign eng_gnt  = !core_act;

    // State register
    always_ff @(posedge CLK_50 or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK_50 or negedge Reset_N) begin
        if (!Reset_N) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
            buf_q  <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            rem_q  <= rem_d;
            data_q <= data_d;
            buf_q  <= buf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        buf_d   = buf_q;
        unique case (state_q)
            StIdle: begin
                if (CmdValid) begin
                    src_d  = mod_words(CmdSrc);
                    dst_d  = mod_words(CmdDst);
                    rem_d  = CmdLen;
                    data_d = CmdData;
                    if (CmdLen == '0) begin
                        state_d = StDone;
                    end else if (CmdOp) begin
                        state_d = StCpRd;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (eng_gnt) begin
                    dst_d = wrap_inc(dst_q);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StCpRd: begin
                if (eng_gnt) begin
                    src_d   = wrap_inc(src_q);
                    state_d = StCpWait;
                end
            end
            // Read data for the CpRd access arrives now regardless of what the
            // core does with the port this cycle, so capture unconditionally.
            StCpWait: begin
                buf_d   = MemRdData;
                state_d = StCpWr;
            end
            StCpWr: begin
                if (eng_gnt) begin
                    dst_d   = wrap_inc(dst_q);
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? StDone : StCpRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Engine port request and status outputs
    always_comb begin
        eng_wr   = 1'b0;
        eng_rd   = 1'b0;
        eng_addr = '0;
        eng_data = '0;
        unique case (state_q)
            StFill: begin
                eng_wr   = 1'b1;
                eng_addr = dst_q;
                eng_data = data_q;
            end
            StCpRd: begin
                eng_rd   = 1'b1;
                eng_addr = src_q;
            end
            StCpWr: begin
                eng_wr   = 1'b1;
                eng_addr = dst_q;
                eng_data = buf_q;
            end
            default: begin
            end
        endcase
    end

    assign CmdReady = (state_q == StIdle);
    assign Busy     = (state_q != StIdle) && (state_q != StDone);
    assign Done     = (state_q == StDone);

    // Port mux: any core request takes the port outright in the same cycle.
    assign MemWrEn   = core_act ? CoreWrEn   : eng_wr;
    assign MemRdEn   = core_act ? CoreRdEn   : eng_rd;
    assign MemAddr   = core_act ? CoreAddr   : eng_addr;
    assign MemWrData = core_act ? CoreWrData : eng_data;
    assign MemByteEn = core_act ? CoreByteEn : 4'hF;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_fill_arb.sv
module tb_rvc_asap_5pl_vga_fill_arb;

    localparam int WORDS  = 9600;
    localparam int ADDR_W = 14;
    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_WAIT = 2;

    logic              CLK_50 = 1'b0;
    logic              Reset_N;
    logic              CoreWrEn, CoreRdEn;
    logic [ADDR_W-1:0] CoreAddr;
    logic [31:0]       CoreWrData;
    logic [3:0]        CoreByteEn;
    logic              CmdValid, CmdReady, CmdOp;
    logic [ADDR_W-1:0] CmdSrc, CmdDst;
    logic [ADDR_W:0]   CmdLen;
    logic [31:0]       CmdData;
    logic              Busy, Done;
    logic              MemWrEn, MemRdEn;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWrData;
    logic [3:0]        MemByteEn;
    logic [31:0]       MemRdData;

    rvc_asap_5pl_vga_fill_arb #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .CLK_50(CLK_50), .Reset_N(Reset_N),
        .CoreWrEn(CoreWrEn), .CoreRdEn(CoreRdEn), .CoreAddr(CoreAddr),
        .CoreWrData(CoreWrData), .CoreByteEn(CoreByteEn),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp), .CmdSrc(CmdSrc),
        .CmdDst(CmdDst), .CmdLen(CmdLen), .CmdData(CmdData),
        .Busy(Busy), .Done(Done),
        .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .MemAddr(MemAddr),
        .MemWrData(MemWrData), .MemByteEn(MemByteEn), .MemRdData(MemRdData)
    );

    always #5 CLK_50 = ~CLK_50;

    int cyc = 0;
    always @(posedge CLK_50) cyc <= cyc + 1;

    // Frame-buffer memory: byte-enabled writes, registered read data.
    bit   [31:0] mem [WORDS];
    logic [31:0] rd_q;
    assign MemRdData = rd_q;
    always @(posedge CLK_50) begin
        if (MemWrEn && int'(MemAddr) < WORDS)
            for (int b = 0; b < 4; b++)
                if (MemByteEn[b]) mem[MemAddr][8*b +: 8] <= MemWrData[8*b +: 8];
        if (MemRdEn && int'(MemAddr) < WORDS) rd_q <= mem[MemAddr];
        else rd_q <= 32'hDEAD_BEEF;
    end

    // Reference model: a command becomes a list of port steps; a port step
    // is consumed only in a cycle with no core request, a wait step always.
    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
        bit          from_copy;
    } step_t;

    step_t       m_q[$];
    int          m_phase = 0;      // 0 idle, 1 running, 2 done pulse due
    logic [31:0] m_copy_val = '0;
    int          m_wr_cnt = 0;
    bit   [31:0] exp_mem [WORDS];

    int checks = 0;
    int failures = 0;

    int wr_log[$];
    int wr_cyc[$];
    int eng_acc, busy_cnt, done_cyc, acc_cyc;
    bit done_seen;

    int core_mode = 0;
    bit did_rd, did_wr;
    logic [31:0] core_rd_val;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic build(input bit op, input int src, input int dst, input int len,
                         input logic [31:0] data);
        int s, d;
        s = src % WORDS;
        d = dst % WORDS;
        for (int i = 0; i < len; i++) begin
            if (!op) begin
                m_q.push_back('{K_WR, (d + i) % WORDS, data, 1'b0});
            end else begin
                m_q.push_back('{K_RD, (s + i) % WORDS, 32'h0, 1'b0});
                m_q.push_back('{K_WAIT, 0, 32'h0, 1'b0});
                m_q.push_back('{K_WR, (d + i) % WORDS, 32'h0, 1'b1});
            end
        end
    endtask

    task automatic model_cycle();
        logic        core_act, e_wr, e_rd, a_wr, a_rd;
        logic [ADDR_W-1:0] e_addr, a_addr;
        logic [31:0] e_data, a_data;
        logic [3:0]  e_be, a_be;
        logic [2:0]  e_ctl;
        step_t       st;
        core_act = CoreWrEn || CoreRdEn;
        e_wr = 0; e_rd = 0; e_addr = '0; e_data = '0; e_be = '0; e_ctl = 3'b100;
        if (!Reset_N) begin
            m_phase = 0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (CmdValid) begin
                    build(CmdOp, int'(CmdSrc), int'(CmdDst), int'(CmdLen), CmdData);
                    m_phase = (m_q.size() == 0) ? 2 : 1;
                end
                1: begin
                    e_ctl = 3'b010;
                    if (m_q[0].kind == K_WAIT) begin
                        st = m_q.pop_front();
                    end else if (!core_act) begin
                        st = m_q.pop_front();
                        e_addr = ADDR_W'(st.addr);
                        if (st.kind == K_RD) begin
                            e_rd = 1;
                            m_copy_val = exp_mem[st.addr];
                        end else begin
                            e_wr = 1;
                            e_data = st.from_copy ? m_copy_val : st.data;
                            e_be = 4'hF;
                            exp_mem[st.addr] = e_data;
                            m_wr_cnt++;
                        end
                    end
                    if (m_q.size() == 0) m_phase = 2;
                end
                default: begin
                    e_ctl = 3'b001;
                    m_phase = 0;
                end
            endcase
        end
        if (core_act) begin
            e_wr = CoreWrEn; e_rd = CoreRdEn; e_addr = CoreAddr;
            e_data = CoreWrData; e_be = CoreByteEn;
            if (CoreWrEn && int'(CoreAddr) < WORDS)
                for (int b = 0; b < 4; b++)
                    if (CoreByteEn[b]) exp_mem[CoreAddr][8*b +: 8] = CoreWrData[8*b +: 8];
        end
        a_wr = MemWrEn; a_rd = MemRdEn;
        a_addr = (a_wr || a_rd) ? MemAddr : '0;
        a_data = a_wr ? MemWrData : '0;
        a_be   = a_wr ? MemByteEn : '0;
        if (!(e_wr || e_rd)) e_addr = '0;
        if (!e_wr) begin e_data = '0; e_be = '0; end
        chk("ctl_ready_busy_done", {CmdReady, Busy, Done}, e_ctl);
        chk("port", {a_wr, a_rd, a_addr, a_data, a_be}, {e_wr, e_rd, e_addr, e_data, e_be});
        if (Reset_N) begin
            if (!core_act && MemWrEn) begin
                wr_log.push_back(int'(MemAddr));
                wr_cyc.push_back(cyc);
            end
            if (!core_act && (MemWrEn || MemRdEn)) eng_acc++;
            if (Busy) busy_cnt++;
            if (Done) begin done_cyc = cyc; done_seen = 1; end
        end
    endtask

    task automatic checker_loop();
        forever begin
            @(negedge CLK_50);
            model_cycle();
        end
    endtask

    task automatic drive_core();
        int r;
        CoreWrEn = 0; CoreRdEn = 0; CoreByteEn = 4'h0;
        case (core_mode)
            1: begin
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    CoreRdEn = 1;
                    CoreAddr = ADDR_W'($urandom_range(0, WORDS - 1));
                end else if (r < 3) begin
                    CoreWrEn = 1;
                    CoreAddr = ADDR_W'(9000 + $urandom_range(0, 99));
                    CoreWrData = $urandom;
                    CoreByteEn = 4'($urandom_range(1, 15));
                end
                // Requests while busy must be ignored.
                if (m_phase == 1 && m_q.size() > 2 && $urandom_range(0, 7) == 0) begin
                    CmdValid = 1; CmdOp = 1'($urandom_range(0, 1));
                    CmdDst = ADDR_W'($urandom_range(0, 7999));
                    CmdSrc = ADDR_W'($urandom_range(0, 7999));
                    CmdLen = 15'($urandom_range(1, 20)); CmdData = $urandom;
                end
            end
            2: if (m_phase == 1 && m_q.size() > 0) begin
                if (m_q[0].kind == K_WAIT && !did_rd) begin
                    CoreRdEn = 1; CoreAddr = 14'd90; did_rd = 1;
                end else if (m_q[0].kind == K_WR && did_rd && !did_wr) begin
                    CoreWrEn = 1; CoreAddr = 14'd9050; CoreWrData = 32'hC0FF_EE00;
                    CoreByteEn = 4'hF; did_wr = 1; core_rd_val = MemRdData;
                end
            end
            3: if (cyc == acc_cyc + 2) begin
                CoreWrEn = 1; CoreAddr = 14'd5; CoreWrData = 32'h11; CoreByteEn = 4'b0011;
            end
            default: begin
            end
        endcase
    endtask

    task automatic tick();
        @(posedge CLK_50);
        #1;
        CmdValid = 1'b0;
        drive_core();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (m_phase != 0 && n < limit) begin tick(); n++; end
        if (n >= limit) begin
            checks++; failures++;
            $display("FAIL cmd_timeout cyc=%0d phase=%0d required=0", cyc, m_phase);
        end
    endtask

    task automatic start_cmd(input bit op, input int src, input int dst, input int len,
                             input logic [31:0] data);
        wait_idle(20000);
        CoreWrEn = 0; CoreRdEn = 0;
        wr_log.delete(); wr_cyc.delete();
        eng_acc = 0; busy_cnt = 0; done_cyc = -1; done_seen = 0;
        did_rd = 0; did_wr = 0;
        CmdValid = 1; CmdOp = op; CmdSrc = ADDR_W'(src); CmdDst = ADDR_W'(dst);
        CmdLen = 15'(len); CmdData = data;
        acc_cyc = cyc;
        tick();
    endtask

    task automatic run_cmd(input bit op, input int src, input int dst, input int len,
                           input logic [31:0] data);
        start_cmd(op, src, dst, len, data);
        wait_idle(20000);
    endtask

    initial begin
        int bad, base, n, src, dst, len;
        Reset_N = 0; CoreWrEn = 0; CoreRdEn = 0; CoreAddr = '0; CoreWrData = '0;
        CoreByteEn = '0; CmdValid = 0; CmdOp = 0; CmdSrc = '0; CmdDst = '0;
        CmdLen = '0; CmdData = '0;
        tick(); tick();
        fork
            checker_loop();
        join_none
        tick();
        chk("reset_ctl", {CmdReady, Busy, Done}, 3'b100);
        Reset_N = 1;
        tick();

        // Uncontended fill
        run_cmd(0, 0, 100, 4, 32'hA5A5_A5A5);
        chk("fill_addrs", {wr_log[0], wr_log[1], wr_log[2], wr_log[3]}, {32'd100, 32'd101, 32'd102, 32'd103});
        chk("fill_nwr", wr_log.size(), 4);
        chk("fill_first", wr_cyc[0], acc_cyc + 1);
        chk("fill_consec", wr_cyc[3] - wr_cyc[0], 3);
        chk("fill_done", done_cyc, wr_cyc[3] + 1);
        chk("fill_busy", busy_cnt, 4);
        chk("fill_mem", {mem[100], mem[103]}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

        // Core store on the second engine cycle
        core_mode = 3;
        run_cmd(0, 0, 100, 4, 32'hA5A5_A5A5);
        core_mode = 0;
        chk("prio_addrs", {wr_log[0], wr_log[1], wr_log[2], wr_log[3]}, {32'd100, 32'd101, 32'd102, 32'd103});
        chk("prio_busy", busy_cnt, 5);
        chk("prio_done", done_cyc, acc_cyc + 6);
        chk("prio_mem5", mem[5], 32'h0000_0011);

        // Scroll copy
        for (int i = 80; i < 240; i++) begin
            CoreWrEn = 1; CoreAddr = ADDR_W'(i); CoreWrData = i; CoreByteEn = 4'hF;
            tick();
        end
        run_cmd(1, 80, 0, 160, 32'h0);
        chk("scroll_busy", busy_cnt, 480);
        chk("scroll_done", done_cyc, acc_cyc + 481);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[i] != 32'(80 + i)) bad++;
        chk("scroll_mem_bad", bad, 0);

        // Copy with core read in the wait slot and core store in the write slot
        core_mode = 2;
        run_cmd(1, 200, 400, 2, 32'h0);
        core_mode = 0;
        chk("cpint_busy", busy_cnt, 7);
        chk("cpint_wr", {wr_cyc[0], wr_cyc[1]}, {acc_cyc + 4, acc_cyc + 7});
        chk("cpint_mem", {mem[400], mem[401], mem[9050]}, {32'd200, 32'd201, 32'hC0FF_EE00});
        chk("cpint_core_rd", core_rd_val, 32'd170);

        // Wrap, out-of-range address and zero length
        run_cmd(0, 0, 9598, 4, 32'h5A5A_0001);
        chk("wrap_addrs", {wr_log[0], wr_log[1], wr_log[2], wr_log[3]}, {32'd9598, 32'd9599, 32'd0, 32'd1});
        run_cmd(0, 0, 9607, 1, 32'h7777_0007);
        chk("fold_addr", {wr_log.size(), wr_log[0]}, {32'd1, 32'd7});
        run_cmd(0, 0, 500, 0, 32'h1);
        chk("len0", {eng_acc, busy_cnt, done_cyc}, {32'd0, 32'd0, acc_cyc + 1});

        // Randomised commands under random core traffic
        core_mode = 1;
        for (int k = 0; k < 40; k++) begin
            src = $urandom_range(0, 7900);
            if ($urandom_range(0, 1) == 1) begin
                dst = src + $urandom_range(0, 10) - 5;
                if (dst < 0) dst = 0;
            end else begin
                dst = $urandom_range(0, 7900);
            end
            len = $urandom_range(0, 40);
            run_cmd(1'($urandom_range(0, 1)), src, dst, len, $urandom);
        end
        core_mode = 0;
        tick();

        // Asynchronous reset in the middle of a copy
        base = m_wr_cnt;
        start_cmd(1, 2000, 4000, 100, 32'h0);
        n = 0;
        while (m_wr_cnt - base < 50 && n < 2000) begin tick(); n++; end
        chk("rst_reached_rem50", m_wr_cnt - base, 50);
        #1 Reset_N = 0;
        #1;
        chk("rst_async_ctl", {CmdReady, Busy, Done}, 3'b100);
        chk("rst_async_port", {MemWrEn, MemRdEn}, 2'b00);
        done_seen = 0;
        tick(); tick(); tick();
        Reset_N = 1;
        tick(); tick();
        chk("rst_ready", {CmdReady, done_seen}, 2'b10);
        run_cmd(0, 0, 3000, 1, 32'h600D_F00D);
        chk("rst_fill", mem[3000], 32'h600D_F00D);
        tick();

        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            chk("mem_final", mem[i], exp_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
